// File: rtl/qs_pkg.sv
// rtl/qs_pkg.sv - shared types and defaults for the quicksort scheduler
package qs_pkg;

    localparam int DEF_IDX_W  = 4;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LAUNCH,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] lo;
        logic [DEF_IDX_W-1:0] hi;
    } range_t;

endpackage

// File: rtl/qs_range_stack.sv
// rtl/qs_range_stack.sv - register-array LIFO of index ranges with dual push
module qs_range_stack #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push_a,
    input  logic          push_b,
    input  logic [W-1:0]  data_a,
    input  logic [W-1:0]  data_b,
    input  logic          pop,
    output logic [W-1:0]  top,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [W-1:0] mem [DEPTH];
    logic [CW:0]  need;

    // push_a lands below push_b when both are requested in the same cycle
    assign need     = {1'b0, count} + (CW+1)'(push_a) + (CW+1)'(push_b);
    assign overflow = need > (CW+1)'(DEPTH);
    assign empty    = (count == '0);
    assign top      = mem[IW'(count - 1'b1)];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end else if ((push_a || push_b) && !overflow) begin
            if (push_a && push_b) count <= count + CW'(2);
            else                  count <= count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && !(pop && !empty) && (push_a || push_b) && !overflow) begin
            if (push_a && push_b) begin
                mem[IW'(count)]        <= data_a;
                mem[IW'(count + 1'b1)] <= data_b;
            end else if (push_a) begin
                mem[IW'(count)] <= data_a;
            end else begin
                mem[IW'(count)] <= data_b;
            end
        end
    end

endmodule

// File: rtl/quicksort_scheduler.sv
// rtl/quicksort_scheduler.sv - iterative quicksort sequencer driving an external partition unit
module quicksort_scheduler
    import qs_pkg::*;
#(
    parameter int ARR_WIDTH   = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [ARR_WIDTH*DATA_W-1:0] array_in,
    input  logic [IDX_W-1:0]            lo_ind,
    input  logic [IDX_W-1:0]            hi_ind,
    output logic                        busy,
    output logic                        array_valid,
    output logic                        error,
    output logic [ARR_WIDTH*DATA_W-1:0] sorted_array,
    output logic [IDX_W:0]              part_count,
    output logic                        part_start,
    output logic [ARR_WIDTH*DATA_W-1:0] part_array,
    output logic [IDX_W-1:0]            part_lo,
    output logic [IDX_W-1:0]            part_hi,
    input  logic [ARR_WIDTH*DATA_W-1:0] part_array_out,
    input  logic [IDX_W-1:0]            part_pivot_ind,
    input  logic                        part_valid
);

    localparam int AW  = ARR_WIDTH * DATA_W;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int SCW = $clog2(STACK_DEPTH + 1);

    state_t               state, state_nx;
    logic [AW-1:0]        work;
    logic [IDX_W-1:0]     pivot;
    logic [TW-1:0]        tmo_cnt;
    logic                 stk_push_a, stk_push_b, stk_pop, stk_clear;
    logic [2*IDX_W-1:0]   stk_data_a, stk_data_b, stk_top;
    logic                 stk_empty, stk_overflow;
    logic [SCW-1:0]       stk_count;
    logic                 push_err, in_push, idle_push;
    logic [IDX_W:0]       p_w, lo_w, hi_w, left_len, right_len;
    logic                 pivot_bad, left_ok, right_ok, left_big;
    logic [2*IDX_W-1:0]   left_rng, right_rng, first_rng, second_rng;

    assign busy       = (state != S_IDLE);
    assign part_start = (state == S_LAUNCH);
    assign part_array = work;

    // Range arithmetic is one bit wider so p=0 and p=max neither underflow nor wrap
    assign p_w       = {1'b0, pivot};
    assign lo_w      = {1'b0, part_lo};
    assign hi_w      = {1'b0, part_hi};
    assign pivot_bad = (pivot < part_lo) || (pivot > part_hi);
    assign left_ok   = p_w > lo_w + 1'b1;
    assign right_ok  = p_w + 1'b1 < hi_w;
    assign left_len  = p_w - lo_w;
    assign right_len = hi_w - p_w;
    assign left_big  = left_len >= right_len;
    assign left_rng  = {part_lo, pivot - 1'b1};
    assign right_rng = {pivot + 1'b1, part_hi};

    // Larger range goes deeper so the smaller one is popped first, bounding stack depth
    assign first_rng  = (left_ok && (!right_ok || left_big)) ? left_rng : right_rng;
    assign second_rng = left_big ? right_rng : left_rng;

    assign idle_push  = (state == S_IDLE) && enable && (lo_ind < hi_ind);
    assign in_push    = (state == S_PUSH) && !pivot_bad;
    assign stk_push_a = idle_push || (in_push && (left_ok || right_ok));
    assign stk_push_b = in_push && left_ok && right_ok;
    assign stk_data_a = (state == S_IDLE) ? {lo_ind, hi_ind} : first_rng;
    assign stk_data_b = second_rng;

    qs_range_stack #(
        .W     (2 * IDX_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .clear    (stk_clear),
        .push_a   (stk_push_a),
        .push_b   (stk_push_b),
        .data_a   (stk_data_a),
        .data_b   (stk_data_b),
        .pop      (stk_pop),
        .top      (stk_top),
        .empty    (stk_empty),
        .count    (stk_count),
        .overflow (stk_overflow)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        push_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_nx = (lo_ind < hi_ind) ? S_POP : S_DONE;
            end
            S_POP: begin
                if (stk_empty) begin
                    state_nx = S_DONE;
                end else begin
                    stk_pop  = 1'b1;
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                // LAUNCH and the first WAIT cycle already account for two cycles
                if (part_valid)                          state_nx = S_PUSH;
                else if (tmo_cnt == TW'(TIMEOUT - 2))    state_nx = S_DONE;
            end
            S_PUSH: begin
                if (pivot_bad || stk_overflow) begin
                    push_err = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_POP;
                end
            end
            S_DONE: begin
                stk_clear = (stk_count != '0);
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            work         <= '0;
            pivot        <= '0;
            tmo_cnt      <= '0;
            part_lo      <= '0;
            part_hi      <= '0;
            sorted_array <= '0;
            array_valid  <= 1'b0;
            error        <= 1'b0;
            part_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        work        <= array_in;
                        array_valid <= 1'b0;
                        error       <= 1'b0;
                        part_count  <= '0;
                    end
                end
                S_POP: begin
                    if (!stk_empty) begin
                        part_lo <= stk_top[2*IDX_W-1 -: IDX_W];
                        part_hi <= stk_top[IDX_W-1:0];
                    end
                end
                S_LAUNCH: tmo_cnt <= '0;
                S_WAIT: begin
                    if (part_valid) begin
                        work  <= part_array_out;
                        pivot <= part_pivot_ind;
                        if (part_count != '1) part_count <= part_count + 1'b1;
                    end else if (tmo_cnt == TW'(TIMEOUT - 2)) begin
                        error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_PUSH: begin
                    if (push_err) error <= 1'b1;
                end
                S_DONE: begin
                    sorted_array <= work;
                    array_valid  <= !error;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quicksort_scheduler.sv
// tb/tb_quicksort_scheduler.sv - directed bench with a behavioural last-element-pivot partition model
module tb_quicksort_scheduler;

    localparam int ARR = 4;
    localparam int DW  = 4;
    localparam int IW  = 4;
    localparam int AW  = ARR * DW;
    localparam int TMO = 255;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [AW-1:0] array_in;
    logic [IW-1:0] lo_ind, hi_ind;
    logic          busy, array_valid, error;
    logic [AW-1:0] sorted_array;
    logic [IW:0]   part_count;
    logic          part_start;
    logic [AW-1:0] part_array;
    logic [IW-1:0] part_lo, part_hi;
    logic [AW-1:0] part_array_out;
    logic [IW-1:0] part_pivot_ind;
    logic          part_valid;

    int passed = 0;
    int total  = 0;
    int start_count = 0;
    int max_depth = 0;
    int lat = 2;
    int mode = 0;

    quicksort_scheduler #(
        .ARR_WIDTH   (ARR),
        .DATA_W      (DW),
        .IDX_W       (IW),
        .STACK_DEPTH (4),
        .TIMEOUT     (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .array_in       (array_in),
        .lo_ind         (lo_ind),
        .hi_ind         (hi_ind),
        .busy           (busy),
        .array_valid    (array_valid),
        .error          (error),
        .sorted_array   (sorted_array),
        .part_count     (part_count),
        .part_start     (part_start),
        .part_array     (part_array),
        .part_lo        (part_lo),
        .part_hi        (part_hi),
        .part_array_out (part_array_out),
        .part_pivot_ind (part_pivot_ind),
        .part_valid     (part_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (part_start === 1'b1) start_count = start_count + 1;
        if (int'(dut.u_stack.count) > max_depth) max_depth = int'(dut.u_stack.count);
    end

    // Partition model: mode 0 normal, 1 never answers, 2 returns pivot 7
    initial begin : model
        logic [DW-1:0] a [ARR];
        logic [DW-1:0] pv, tmp;
        int lo_i, hi_i, ii;
        part_valid     = 1'b0;
        part_array_out = '0;
        part_pivot_ind = '0;
        forever begin
            @(posedge clock); #1;
            if (part_start === 1'b1 && mode != 1) begin
                for (int k = 0; k < ARR; k++) a[k] = part_array[k*DW +: DW];
                lo_i = int'(part_lo);
                hi_i = int'(part_hi);
                pv   = a[hi_i];
                ii   = lo_i;
                for (int j = lo_i; j < hi_i; j++) begin
                    if (a[j] < pv) begin
                        tmp = a[ii]; a[ii] = a[j]; a[j] = tmp;
                        ii++;
                    end
                end
                tmp = a[ii]; a[ii] = a[hi_i]; a[hi_i] = tmp;
                repeat (lat - 1) begin @(posedge clock); #1; end
                if (mode == 2) begin
                    part_array_out = part_array;
                    part_pivot_ind = 4'd7;
                end else begin
                    for (int k = 0; k < ARR; k++) part_array_out[k*DW +: DW] = a[k];
                    part_pivot_ind = IW'(ii);
                end
                part_valid = 1'b1;
                @(posedge clock); #1;
                part_valid = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic start_job(input logic [AW-1:0] arr, input logic [IW-1:0] lo, input logic [IW-1:0] hi);
        enable   = 1'b1;
        array_in = arr;
        lo_ind   = lo;
        hi_ind   = hi;
        tick();
        enable   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_start;
        int k;
        k = 0;
        while (part_start !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total++;
        if (part_start !== 1'b1) $display("FAIL wait_start part_start=%b required=1", part_start);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; array_in = '0; lo_ind = '0; hi_ind = '0;
        #2 reset = 1'b0;
        tick(); tick();
        total++;
        if ({busy, array_valid, error, part_start} !== 4'b0000)
            $display("FAIL reset_flags actual=%b required=0000", {busy, array_valid, error, part_start});
        else passed++;
        total++;
        if (sorted_array !== 16'h0 || part_count !== 5'd0)
            $display("FAIL reset_data sorted=%h count=%0d required 0/0", sorted_array, part_count);
        else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int n;
        mode = 0; lat = 2;
        start_job(16'h0213, 4'd0, 4'd3);
        wait_idle(n);
        total++;
        if (busy !== 1'b0) $display("FAIL basic_done busy=%b required=0", busy); else passed++;
        total++;
        if (sorted_array !== 16'h3210) $display("FAIL basic_sorted actual=%h required=3210", sorted_array); else passed++;
        total++;
        if (array_valid !== 1'b1 || error !== 1'b0)
            $display("FAIL basic_flags valid=%b error=%b required 1/0", array_valid, error);
        else passed++;
        total++;
        if (part_count !== 5'd3) $display("FAIL basic_count actual=%0d required=3", part_count); else passed++;
    endtask

    task automatic test_single;
        int s0;
        s0 = start_count;
        start_job(16'h8765, 4'd2, 4'd2);
        total++;
        if (array_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_early valid=%b busy=%b required 0/1", array_valid, busy);
        else passed++;
        tick();
        total++;
        if (array_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL single_valid valid=%b busy=%b required 1/0", array_valid, busy);
        else passed++;
        total++;
        if (sorted_array !== 16'h8765) $display("FAIL single_data actual=%h required=8765", sorted_array); else passed++;
        start_job(16'h4321, 4'd3, 4'd1);
        tick();
        total++;
        if (array_valid !== 1'b1 || part_count !== 5'd0 || start_count != s0)
            $display("FAIL inverted_range valid=%b count=%0d starts=%0d required 1/0/0",
                     array_valid, part_count, start_count - s0);
        else passed++;
    endtask

    task automatic test_presorted;
        int n;
        max_depth = 0;
        start_job(16'h3210, 4'd0, 4'd3);
        wait_idle(n);
        total++;
        if (part_count !== 5'd3) $display("FAIL presorted_count actual=%0d required=3", part_count); else passed++;
        total++;
        if (max_depth > 2) $display("FAIL presorted_depth actual=%0d required<=2", max_depth); else passed++;
        total++;
        if (sorted_array !== 16'h3210 || array_valid !== 1'b1)
            $display("FAIL presorted_data actual=%h valid=%b required 3210/1", sorted_array, array_valid);
        else passed++;
    endtask

    task automatic test_subrange;
        int n;
        start_job(16'h1349, 4'd1, 4'd2);
        wait_idle(n);
        total++;
        if (sorted_array !== 16'h1439 || part_count !== 5'd1)
            $display("FAIL subrange actual=%h count=%0d required 1439/1", sorted_array, part_count);
        else passed++;
    endtask

    task automatic test_timeout;
        int n;
        mode = 1;
        start_job(16'h0213, 4'd0, 4'd3);
        wait_start();
        n = 0;
        while (error !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (n != TMO) $display("FAIL timeout_cycles actual=%0d required=%0d", n, TMO); else passed++;
        tick();
        total++;
        if (array_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b1)
            $display("FAIL timeout_end valid=%b busy=%b error=%b required 0/0/1", array_valid, busy, error);
        else passed++;
        mode = 0;
    endtask

    task automatic test_bad_pivot;
        int n;
        mode = 2;
        start_job(16'h0213, 4'd0, 4'd3);
        wait_idle(n);
        total++;
        if (error !== 1'b1 || array_valid !== 1'b0 || part_count !== 5'd1)
            $display("FAIL bad_pivot error=%b valid=%b count=%0d required 1/0/1", error, array_valid, part_count);
        else passed++;
        mode = 0;
        start_job(16'h0213, 4'd1, 4'd1);
        total++;
        if (error !== 1'b0) $display("FAIL error_clear actual=%b required=0", error); else passed++;
        tick();
        total++;
        if (array_valid !== 1'b1 || sorted_array !== 16'h0213)
            $display("FAIL after_error valid=%b data=%h required 1/0213", array_valid, sorted_array);
        else passed++;
    endtask

    task automatic test_reset_abort;
        int s0;
        lat = 6;
        start_job(16'h3210, 4'd0, 4'd3);
        wait_start();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({busy, array_valid, error, part_start} !== 4'b0000)
            $display("FAIL abort_flags actual=%b required=0000", {busy, array_valid, error, part_start});
        else passed++;
        total++;
        if (sorted_array !== 16'h0 || part_lo !== 4'd0 || part_hi !== 4'd0 || part_array !== 16'h0)
            $display("FAIL abort_data sorted=%h lo=%0d hi=%0d arr=%h required all 0",
                     sorted_array, part_lo, part_hi, part_array);
        else passed++;
        tick(); tick();
        reset = 1'b1;
        s0 = start_count;
        repeat (12) tick();
        total++;
        if (start_count != s0 || busy !== 1'b0)
            $display("FAIL abort_quiet starts=%0d busy=%b required 0/0", start_count - s0, busy);
        else passed++;
        lat = 2;
    endtask

    task automatic test_enable_while_busy;
        int n;
        start_job(16'h0213, 4'd0, 4'd3);
        enable   = 1'b1;
        array_in = 16'hFFFF;
        lo_ind   = 4'd0;
        hi_ind   = 4'd0;
        repeat (3) tick();
        enable = 1'b0;
        wait_idle(n);
        total++;
        if (sorted_array !== 16'h3210 || part_count !== 5'd3 || array_valid !== 1'b1)
            $display("FAIL busy_enable data=%h count=%0d valid=%b required 3210/3/1",
                     sorted_array, part_count, array_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_presorted();
        test_subrange();
        test_timeout();
        test_bad_pivot();
        test_reset_abort();
        test_enable_while_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
